// File: rtl/dmem_mmio_ctrl_pkg.sv
// Shared encodings for the data-memory stage: access sizes, MMIO register map
// and STATUS bit layout.
package dmem_mmio_ctrl_pkg;

    localparam logic [2:0] MEM_W  = 3'd0;
    localparam logic [2:0] MEM_HS = 3'd1;
    localparam logic [2:0] MEM_HU = 3'd2;
    localparam logic [2:0] MEM_BS = 3'd3;
    localparam logic [2:0] MEM_BU = 3'd4;

    // MMIO register select, taken from addr[3:2]
    localparam logic [1:0] REG_TIMER_CNT = 2'd0;
    localparam logic [1:0] REG_TIMER_CMP = 2'd1;
    localparam logic [1:0] REG_STATUS    = 2'd2;
    localparam logic [1:0] REG_IRQ_EN    = 2'd3;

    localparam int STATUS_W   = 5;
    localparam int ST_TIMER   = 0;
    localparam int ST_BTN_LSB = 1;

    typedef enum logic [1:0] {
        SZ_WORD,
        SZ_HALF,
        SZ_BYTE
    } acc_size_e;

    // Codes 5..7 fall through to word access.
    function automatic acc_size_e size_of(input logic [2:0] ctrl);
        case (ctrl)
            MEM_HS, MEM_HU: return SZ_HALF;
            MEM_BS, MEM_BU: return SZ_BYTE;
            default:        return SZ_WORD;
        endcase
    endfunction

    function automatic logic is_signed(input logic [2:0] ctrl);
        return (ctrl == MEM_HS) || (ctrl == MEM_BS);
    endfunction

endpackage

// File: rtl/dmem_mmio_ctrl_mmio.sv
// MMIO page: prescaled timer with compare, button edge latch, W1C status,
// interrupt enable and the registered interrupt line.
module mmio_timer_irq
    import dmem_mmio_ctrl_pkg::*;
#(
    parameter int unsigned PRESCALE = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        we_i,
    input  logic [1:0]  sel_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  buttons_i,
    output logic [31:0] rdata_o,
    output logic        intr_o
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0]       presc_q, presc_d;
    logic [31:0]         cnt_q, cnt_d;
    logic [31:0]         cmp_q, cmp_d;
    logic [STATUS_W-1:0] status_q, status_d;
    logic [STATUS_W-1:0] irq_en_q, irq_en_d;
    logic [3:0]          sync1_q, sync2_q, btn_prev_q;
    logic                intr_q;

    logic                tick, match;
    logic [31:0]         cnt_inc;
    logic [3:0]          rise;
    logic [STATUS_W-1:0] clr;

    // Timer, compare, status and enable next-state; set beats W1C on the same bit.
    always_comb begin
        tick     = (presc_q == PRE_LAST);
        cnt_inc  = cnt_q + 32'd1;
        match    = tick && (cmp_q != 32'd0) && (cnt_inc == cmp_q);
        rise     = sync2_q & ~btn_prev_q;
        presc_d  = tick ? '0 : presc_q + PW'(1);
        cnt_d    = tick ? (match ? 32'd0 : cnt_inc) : cnt_q;
        cmp_d    = cmp_q;
        irq_en_d = irq_en_q;
        clr      = '0;
        if (we_i) begin
            case (sel_i)
                REG_TIMER_CNT: begin
                    presc_d = '0;
                    cnt_d   = 32'd0;
                end
                REG_TIMER_CMP: cmp_d    = wdata_i;
                REG_STATUS:    clr      = wdata_i[STATUS_W-1:0];
                default:       irq_en_d = wdata_i[STATUS_W-1:0];
            endcase
        end
        status_d = (status_q & ~clr) | {rise, match};
    end

    // MMIO register state, synchronizer/edge flops and interrupt output.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc_q    <= '0;
            cnt_q      <= '0;
            cmp_q      <= '0;
            status_q   <= '0;
            irq_en_q   <= '0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            btn_prev_q <= '0;
            intr_q     <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            cnt_q      <= cnt_d;
            cmp_q      <= cmp_d;
            status_q   <= status_d;
            irq_en_q   <= irq_en_d;
            sync1_q    <= buttons_i;
            sync2_q    <= sync1_q;
            btn_prev_q <= sync2_q;
            intr_q     <= |(status_q & irq_en_q);
        end
    end

    // Read mux; unused upper bits of STATUS and IRQ_EN read as zero.
    always_comb begin
        case (sel_i)
            REG_TIMER_CNT: rdata_o = cnt_q;
            REG_TIMER_CMP: rdata_o = cmp_q;
            REG_STATUS:    rdata_o = {{(32-STATUS_W){1'b0}}, status_q};
            default:       rdata_o = {{(32-STATUS_W){1'b0}}, irq_en_q};
        endcase
    end

    assign intr_o = intr_q;

endmodule

// File: rtl/dmem_mmio_ctrl.sv
// Data-memory stage: word RAM with byte/half lanes and load extension,
// address decode, misalignment flag, and the MMIO timer/interrupt page.
module dmem_mmio_ctrl
    import dmem_mmio_ctrl_pkg::*;
#(
    parameter int unsigned RAM_WORDS = 2048,
    parameter logic [31:0] RAM_BASE  = 32'h10010000,
    parameter logic [31:0] MMIO_BASE = 32'h10020000,
    parameter int unsigned PRESCALE  = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  dMemControl,
    input  logic        dMemWena,
    input  logic [3:0]  buttons,
    output logic [31:0] out,
    output logic        intr,
    output logic        align_err
);

    localparam int AW = $clog2(RAM_WORDS);
    localparam logic [32:0] RAM_END = {1'b0, RAM_BASE} + 33'(4 * RAM_WORDS);

    logic [31:0]   mem_q [RAM_WORDS];
    logic          align_err_q;

    acc_size_e     size;
    logic          sgn, ram_hit, mmio_hit, misaligned;
    logic [AW-1:0] ram_idx;
    logic [3:0]    lane_en;
    logic [31:0]   wdata_lanes, mmio_wdata, mmio_rdata, rword;
    logic [15:0]   half_sel;
    logic [7:0]    byte_sel;

    assign size       = size_of(dMemControl);
    assign sgn        = is_signed(dMemControl);
    assign ram_hit    = ({1'b0, addr} >= {1'b0, RAM_BASE}) && ({1'b0, addr} < RAM_END);
    assign mmio_hit   = (addr[31:4] == MMIO_BASE[31:4]);
    assign ram_idx    = addr[AW+1:2] - RAM_BASE[AW+1:2];
    assign misaligned = ((size == SZ_WORD) && (addr[1:0] != 2'b00)) ||
                        ((size == SZ_HALF) && addr[0]);

    // Lane enables and replicated store data; misaligned offsets are dropped.
    always_comb begin
        lane_en     = 4'b1111;
        wdata_lanes = wdata;
        mmio_wdata  = wdata;
        case (size)
            SZ_HALF: begin
                lane_en     = addr[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{wdata[15:0]}};
                mmio_wdata  = {{16{sgn & wdata[15]}}, wdata[15:0]};
            end
            SZ_BYTE: begin
                lane_en     = 4'b0001 << addr[1:0];
                wdata_lanes = {4{wdata[7:0]}};
                mmio_wdata  = {{24{sgn & wdata[7]}}, wdata[7:0]};
            end
            default: ;
        endcase
    end

    // RAM store port; contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (dMemWena && ram_hit) begin
            for (int k = 0; k < 4; k++) begin
                if (lane_en[k]) mem_q[ram_idx][8*k +: 8] <= wdata_lanes[8*k +: 8];
            end
        end
    end

    // Combinational load path: region select, lane pick, extension.
    always_comb begin
        if (ram_hit)       rword = mem_q[ram_idx];
        else if (mmio_hit) rword = mmio_rdata;
        else               rword = 32'd0;
        half_sel = addr[1] ? rword[31:16] : rword[15:0];
        byte_sel = 8'(rword >> {addr[1:0], 3'b000});
        case (size)
            SZ_HALF: out = {{16{sgn & half_sel[15]}}, half_sel};
            SZ_BYTE: out = {{24{sgn & byte_sel[7]}}, byte_sel};
            default: out = rword;
        endcase
    end

    // One-cycle flag following any cycle that presented a misaligned address.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) align_err_q <= 1'b0;
        else       align_err_q <= misaligned;
    end

    assign align_err = align_err_q;

    mmio_timer_irq #(
        .PRESCALE (PRESCALE)
    ) u_mmio (
        .clock     (clock),
        .reset     (reset),
        .we_i      (dMemWena && mmio_hit),
        .sel_i     (addr[3:2]),
        .wdata_i   (mmio_wdata),
        .buttons_i (buttons),
        .rdata_o   (mmio_rdata),
        .intr_o    (intr)
    );

endmodule

// File: tb/tb_dmem_mmio_ctrl.sv
// Directed bench for dmem_mmio_ctrl: loads/stores, misalignment, decode,
// timer match interrupt, button edges and asynchronous reset.
module tb_dmem_mmio_ctrl;
    import dmem_mmio_ctrl_pkg::*;

    localparam logic [31:0] RAM = 32'h10010000;
    localparam logic [31:0] IO  = 32'h10020000;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] addr, wdata, out;
    logic [2:0]  dMemControl;
    logic        dMemWena, intr, align_err;
    logic [3:0]  buttons;

    int total = 0;
    int bad   = 0;

    dmem_mmio_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .addr        (addr),
        .wdata       (wdata),
        .dMemControl (dMemControl),
        .dMemWena    (dMemWena),
        .buttons     (buttons),
        .out         (out),
        .intr        (intr),
        .align_err   (align_err)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] c);
        @(negedge clock);
        addr = a; wdata = d; dMemControl = c; dMemWena = 1'b1;
        @(negedge clock);
        dMemWena = 1'b0; addr = RAM; dMemControl = MEM_W;
    endtask

    task automatic set_load(input logic [31:0] a, input logic [2:0] c);
        @(negedge clock);
        addr = a; dMemControl = c;
        #1;
    endtask

    task automatic test_reset;
        total++; if (intr !== 1'b0) begin bad++; $display("FAIL rst_intr: got %b want 0", intr); end
        total++; if (align_err !== 1'b0) begin bad++; $display("FAIL rst_align: got %b want 0", align_err); end
        @(negedge clock); reset = 1'b0;
        set_load(IO + 32'h4, MEM_W);
        total++; if (out !== 32'h0) begin bad++; $display("FAIL rst_cmp: got %h want 0", out); end
        addr = IO + 32'h8; #1;
        total++; if (out !== 32'h0) begin bad++; $display("FAIL rst_status: got %h want 0", out); end
        addr = IO + 32'hC; #1;
        total++; if (out !== 32'h0) begin bad++; $display("FAIL rst_irqen: got %h want 0", out); end
    endtask

    task automatic test_loads;
        logic [31:0] la [9];
        logic [2:0]  lc [9];
        logic [31:0] le [9];
        la = '{RAM+3, RAM+3, RAM+2, RAM+2, RAM+0, RAM+1, RAM+0, RAM+0, RAM+0};
        lc = '{MEM_BS, MEM_BU, MEM_HS, MEM_HU, MEM_BS, MEM_BU, MEM_HS, MEM_W, 3'd7};
        le = '{32'hFFFFFF88, 32'h00000088, 32'hFFFF8899, 32'h00008899, 32'hFFFFFFBB,
               32'h000000AA, 32'hFFFFAABB, 32'h8899AABB, 32'h8899AABB};
        do_store(RAM, 32'h8899AABB, MEM_W);
        for (int i = 0; i < 9; i++) begin
            set_load(la[i], lc[i]);
            total++;
            if (out !== le[i]) begin
                bad++; $display("FAIL load%0d: got %h want %h", i, out, le[i]);
            end
        end
    endtask

    task automatic test_stores;
        do_store(RAM, 32'hAABBCCDD, MEM_W);
        do_store(RAM + 1, 32'h12345677, MEM_BU);
        set_load(RAM, MEM_W);
        total++; if (out !== 32'hAABB77DD) begin bad++; $display("FAIL sb_lane: got %h want aabb77dd", out); end
        do_store(RAM + 2, 32'hFFFF1234, MEM_HS);
        set_load(RAM, MEM_W);
        total++; if (out !== 32'h123477DD) begin bad++; $display("FAIL sh_lane: got %h want 123477dd", out); end
    endtask

    task automatic test_misaligned;
        do_store(RAM + 4, 32'hCAFEF00D, MEM_W);
        set_load(RAM + 6, MEM_W);
        total++; if (out !== 32'hCAFEF00D) begin bad++; $display("FAIL mis_lw: got %h want cafef00d", out); end
        total++; if (align_err !== 1'b0) begin bad++; $display("FAIL mis_early: got %b want 0", align_err); end
        @(negedge clock);
        total++; if (align_err !== 1'b1) begin bad++; $display("FAIL mis_pulse: got %b want 1", align_err); end
        addr = RAM;
        @(negedge clock);
        total++; if (align_err !== 1'b0) begin bad++; $display("FAIL mis_end: got %b want 0", align_err); end
        set_load(RAM + 3, MEM_HS);
        total++; if (out !== 32'h00001234) begin bad++; $display("FAIL mis_lh: got %h want 00001234", out); end
        do_store(RAM + 5, 32'h00005A5A, MEM_HU);
        total++; if (align_err !== 1'b1) begin bad++; $display("FAIL mis_st_pulse: got %b want 1", align_err); end
        set_load(RAM + 4, MEM_W);
        total++; if (out !== 32'hCAFE5A5A) begin bad++; $display("FAIL mis_sh: got %h want cafe5a5a", out); end
    endtask

    task automatic test_decode;
        set_load(32'h0, MEM_W);
        total++; if (out !== 32'h0) begin bad++; $display("FAIL miss_load: got %h want 0", out); end
        do_store(32'h0, 32'hDEADBEEF, MEM_W);
        set_load(32'h0, MEM_W);
        total++; if (out !== 32'h0) begin bad++; $display("FAIL miss_store: got %h want 0", out); end
        set_load(RAM, MEM_W);
        total++; if (out !== 32'h123477DD) begin bad++; $display("FAIL miss_noalias: got %h want 123477dd", out); end
        do_store(RAM + 32'h1FFC, 32'h0BADCAFE, MEM_W);
        set_load(RAM + 32'h1FFC, MEM_W);
        total++; if (out !== 32'h0BADCAFE) begin bad++; $display("FAIL last_word: got %h want 0badcafe", out); end
        do_store(RAM + 32'h2000, 32'h11111111, MEM_W);
        do_store(RAM - 32'h4, 32'h22222222, MEM_W);
        set_load(RAM + 32'h2000, MEM_W);
        total++; if (out !== 32'h0) begin bad++; $display("FAIL past_end: got %h want 0", out); end
        set_load(RAM, MEM_W);
        total++; if (out !== 32'h123477DD) begin bad++; $display("FAIL end_alias: got %h want 123477dd", out); end
        set_load(RAM + 32'h1FFC, MEM_W);
        total++; if (out !== 32'h0BADCAFE) begin bad++; $display("FAIL below_alias: got %h want 0badcafe", out); end
    endtask

    task automatic test_timer;
        do_store(IO + 32'h0, 32'h0, MEM_W);
        do_store(IO + 32'h4, 32'd3, MEM_W);
        do_store(IO + 32'h8, 32'h1F, MEM_W);
        do_store(IO + 32'hC, 32'h1, MEM_W);
        do_store(IO + 32'h0, 32'h0, MEM_W);
        addr = IO + 32'h8;
        repeat (47) @(negedge clock);
        addr = IO + 32'h0; #1;
        total++; if (out !== 32'd2) begin bad++; $display("FAIL tmr_cnt47: got %h want 2", out); end
        addr = IO + 32'h8; #1;
        total++; if (out !== 32'h0) begin bad++; $display("FAIL tmr_early: got %h want 0", out); end
        @(negedge clock);
        total++; if (out !== 32'h1) begin bad++; $display("FAIL tmr_match: got %h want 1", out); end
        total++; if (intr !== 1'b0) begin bad++; $display("FAIL tmr_intr_lat: got %b want 0", intr); end
        addr = IO + 32'h0; #1;
        total++; if (out !== 32'd0) begin bad++; $display("FAIL tmr_cnt_wrap: got %h want 0", out); end
        addr = IO + 32'h8;
        @(negedge clock);
        total++; if (intr !== 1'b1) begin bad++; $display("FAIL tmr_intr: got %b want 1", intr); end
        do_store(IO + 32'h8, 32'h1, MEM_W);
        addr = IO + 32'h8; #1;
        total++; if (out !== 32'h0) begin bad++; $display("FAIL tmr_w1c: got %h want 0", out); end
        total++; if (intr !== 1'b1) begin bad++; $display("FAIL tmr_intr_hold: got %b want 1", intr); end
        @(negedge clock);
        total++; if (intr !== 1'b0) begin bad++; $display("FAIL tmr_intr_clr: got %b want 0", intr); end
        do_store(IO + 32'h4, 32'h0, MEM_W);
        do_store(IO + 32'h8, 32'h1F, MEM_W);
    endtask

    task automatic test_buttons;
        do_store(IO + 32'hC, 32'h8, MEM_W);
        @(negedge clock);
        buttons = 4'b0100; addr = IO + 32'h8;
        @(negedge clock);
        @(negedge clock);
        total++; if (out !== 32'h0) begin bad++; $display("FAIL btn_early: got %h want 0", out); end
        @(negedge clock);
        total++; if (out !== 32'h8) begin bad++; $display("FAIL btn_set: got %h want 8", out); end
        total++; if (intr !== 1'b0) begin bad++; $display("FAIL btn_intr_lat: got %b want 0", intr); end
        @(negedge clock);
        total++; if (intr !== 1'b1) begin bad++; $display("FAIL btn_intr: got %b want 1", intr); end
        do_store(IO + 32'h8, 32'h8, MEM_W);
        addr = IO + 32'h8;
        repeat (6) @(negedge clock);
        total++; if (out !== 32'h0) begin bad++; $display("FAIL btn_held: got %h want 0", out); end
        total++; if (intr !== 1'b0) begin bad++; $display("FAIL btn_held_intr: got %b want 0", intr); end
        buttons = 4'b0000;
        repeat (4) @(negedge clock);
        buttons = 4'b0100;
        @(negedge clock);
        @(negedge clock);
        addr = IO + 32'h8; wdata = 32'h8; dMemControl = MEM_W; dMemWena = 1'b1;
        @(negedge clock);
        dMemWena = 1'b0; #1;
        total++; if (out !== 32'h8) begin bad++; $display("FAIL btn_set_wins: got %h want 8", out); end
        @(negedge clock);
        total++; if (intr !== 1'b1) begin bad++; $display("FAIL btn_intr2: got %b want 1", intr); end
    endtask

    task automatic test_reset_mid;
        do_store(IO + 32'h4, 32'd5, MEM_W);
        total++; if (intr !== 1'b1) begin bad++; $display("FAIL mid_pre_intr: got %b want 1", intr); end
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        total++; if (intr !== 1'b0) begin bad++; $display("FAIL mid_intr: got %b want 0", intr); end
        addr = IO + 32'h4; dMemControl = MEM_W; #1;
        total++; if (out !== 32'h0) begin bad++; $display("FAIL mid_cmp: got %h want 0", out); end
        addr = IO + 32'h8; #1;
        total++; if (out !== 32'h0) begin bad++; $display("FAIL mid_status: got %h want 0", out); end
        @(negedge clock);
        reset = 1'b0;
        set_load(RAM, MEM_W);
        total++; if (out !== 32'h123477DD) begin bad++; $display("FAIL mid_ram0: got %h want 123477dd", out); end
        set_load(RAM + 32'h1FFC, MEM_W);
        total++; if (out !== 32'h0BADCAFE) begin bad++; $display("FAIL mid_ram_last: got %h want 0badcafe", out); end
    endtask

    initial begin
        reset = 1'b1; addr = RAM; wdata = 32'h0; dMemControl = MEM_W;
        dMemWena = 1'b0; buttons = 4'b0000;
        repeat (3) @(negedge clock);
        test_reset;
        test_loads;
        test_stores;
        test_misaligned;
        test_decode;
        test_timer;
        test_buttons;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
